// File: rtl/rx_serial_7e2_if.sv
// Character bus from the serial receiver to the measurement/transmit control unit.
// pronto is a valid-only strobe: one cycle high per frame, data and flags stable while high, no ready/backpressure.
interface rx_serial_7e2_if;
  logic [6:0] dados_ascii;
  logic       erro_paridade;
  logic       erro_frame;
  logic       pronto;

  modport master (output dados_ascii, erro_paridade, erro_frame, pronto);
  modport slave  (input  dados_ascii, erro_paridade, erro_frame, pronto);
endinterface

// File: rtl/rx_serial_7e2.sv
// UART receiver, 7 data bits, even parity, 2 stop bits, LSB first.
// Samples mid-bit (start bit at H clocks, then every M) and pulses pronto once per frame.
module rx_serial_7e2 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            zera,
  input  logic            RX,
  output logic [3:0]      db_estado,
  rx_serial_7e2_if.master rx_out
);
  localparam int M  = CLK_FREQ / BAUD;
  localparam int H  = M / 2;
  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] CNT_MID = CW'(H - 1);
  localparam logic [CW-1:0] CNT_END = CW'(M - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    STOP1    = 4'd4,
    STOP2    = 4'd5,
    FINAL    = 4'd6
  } state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [6:0]    shreg;
  logic          par_bit, stop1_bit;
  logic [6:0]    dados_r;
  logic          erro_p_r, erro_f_r;
  logic          tick_mid, tick_end;

  assign tick_mid = (cnt == CNT_MID);
  assign tick_end = (cnt == CNT_END);

  // RX is asynchronous; idle-high reset keeps INICIAL from seeing a false start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else if (zera) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     state <= INICIAL;
    else if (zera) state <= INICIAL;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INICIAL:  if (!rx_s) state_nx = START;
      START:    if (tick_mid) state_nx = rx_s ? INICIAL : DADOS;
      DADOS:    if (tick_end && idx == 3'd6) state_nx = PARIDADE;
      PARIDADE: if (tick_end) state_nx = STOP1;
      STOP1:    if (tick_end) state_nx = STOP2;
      STOP2:    if (tick_end) state_nx = FINAL;
      FINAL:    state_nx = INICIAL;
      default:  state_nx = INICIAL;
    endcase
  end

  always_comb begin
    case (state)
      INICIAL, START, DADOS, PARIDADE, STOP1, STOP2, FINAL: db_estado = state;
      default: db_estado = 4'hF;
    endcase
  end

  assign rx_out.pronto        = (state == FINAL);
  assign rx_out.dados_ascii   = dados_r;
  assign rx_out.erro_paridade = erro_p_r;
  assign rx_out.erro_frame    = erro_f_r;

  // cnt restarts at every sample point, so it never exceeds M-1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par_bit   <= 1'b1;
      stop1_bit <= 1'b1;
      dados_r   <= '0;
      erro_p_r  <= 1'b0;
      erro_f_r  <= 1'b0;
    end else if (zera) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par_bit   <= 1'b1;
      stop1_bit <= 1'b1;
      dados_r   <= '0;
      erro_p_r  <= 1'b0;
      erro_f_r  <= 1'b0;
    end else begin
      case (state)
        START: begin
          cnt <= tick_mid ? '0 : cnt + 1'b1;
          idx <= '0;
        end
        DADOS, PARIDADE, STOP1, STOP2: cnt <= tick_end ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase

      if (tick_end) begin
        case (state)
          DADOS: begin
            shreg <= {rx_s, shreg[6:1]};
            idx   <= idx + 3'd1;
          end
          PARIDADE: par_bit   <= rx_s;
          STOP1:    stop1_bit <= rx_s;
          STOP2: begin
            // Loaded on the edge into FINAL so they are valid while pronto is high
            dados_r  <= shreg;
            erro_p_r <= ^{shreg, par_bit};
            erro_f_r <= ~(stop1_bit & rx_s);
          end
          default: ;
        endcase
      end
    end
  end
endmodule
